// File: rtl/rst_pulse_seq_pkg.sv
// Shared channel state type, default sizes and the chain hand-off helper for rst_pulse_seq.
package rst_pulse_seq_pkg;

    localparam int DEF_N_CH    = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int PULSE_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ASSERT = 2'd2,
        DONE   = 2'd3
    } chState_t;

    // True when a channel reaches DONE on the coming edge; a launch with zero
    // delay and zero duration lands in DONE immediately.
    function automatic logic entersDone(input chState_t state,
                                        input logic     launch,
                                        input logic     cntIsOne,
                                        input logic     delayIsZero,
                                        input logic     durIsZero);
        logic result;
        result = 1'b0;
        if (launch) begin
            result = delayIsZero && durIsZero;
        end else begin
            case (state)
                DELAY:   result = cntIsOne && durIsZero;
                ASSERT:  result = cntIsOne;
                default: result = 1'b0;
            endcase
        end
        return result;
    endfunction

endpackage

// File: rtl/rst_pulse_seq_ch.sv
// One reset-output channel: IDLE/DELAY/ASSERT/DONE state machine with a non-wrapping down-counter.
// Optional 8-bit saturating pulse counter when RST_PULSE_SEQ_CNT_EN is defined.
module rst_pulse_ch
    import rst_pulse_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_launch,
    input  logic             i_clear,
    input  logic             i_pol,
    input  logic [CNT_W-1:0] i_delay,
    input  logic [CNT_W-1:0] i_dur,
    output chState_t         o_state,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_rstOut
`ifdef RST_PULSE_SEQ_CNT_EN
    ,
    output logic [PULSE_CNT_W-1:0] o_pulseCnt
`endif
);

    chState_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_act;

    // Counters are loaded with the full value and leave their state on a count of one,
    // so the all-ones value is usable without wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_act   <= 1'b0;
        end else begin
            r_act <= (r_state == ASSERT);
            if (i_launch) begin
                if (i_delay != '0) begin
                    r_state <= DELAY;
                    r_cnt   <= i_delay;
                end else if (i_dur != '0) begin
                    r_state <= ASSERT;
                    r_cnt   <= i_dur;
                end else begin
                    r_state <= DONE;
                    r_cnt   <= '0;
                end
            end else begin
                case (r_state)
                    DELAY: begin
                        if (r_cnt == CNT_W'(1)) begin
                            if (i_dur != '0) begin
                                r_state <= ASSERT;
                                r_cnt   <= i_dur;
                            end else begin
                                r_state <= DONE;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ASSERT: begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    DONE: begin
                        if (i_clear) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

`ifdef RST_PULSE_SEQ_CNT_EN
    logic [PULSE_CNT_W-1:0] r_pulseCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulseCnt <= '0;
        end else if ((r_state == ASSERT) && (r_cnt == CNT_W'(1)) && !i_launch
                     && (r_pulseCnt != {PULSE_CNT_W{1'b1}})) begin
            r_pulseCnt <= r_pulseCnt + PULSE_CNT_W'(1);
        end
    end

    assign o_pulseCnt = r_pulseCnt;
`endif

    assign o_state  = r_state;
    assign o_cnt    = r_cnt;
    // Polarity is applied live so a polarity change shows even while the channel is idle.
    assign o_rstOut = r_act ? i_pol : ~i_pol;

endmodule

// File: rtl/rst_pulse_seq.sv
// Multi-channel reset pulse sequencer: snapshots the configuration on start and runs channels in parallel or chained.
// Defining RST_PULSE_SEQ_CNT_EN adds the per-channel pulse_cnt output.
module rst_pulse_seq
    import rst_pulse_seq_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  chain_mode,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [N_CH-1:0]       ch_pol,
    input  logic [N_CH*CNT_W-1:0] ch_delay,
    input  logic [N_CH*CNT_W-1:0] ch_dur,
    output logic [N_CH-1:0]       rst_out,
    output logic                  busy,
    output logic                  done
`ifdef RST_PULSE_SEQ_CNT_EN
    ,
    output logic [N_CH*PULSE_CNT_W-1:0] pulse_cnt
`endif
);

    logic [N_CH-1:0]       r_snapEn;
    logic [N_CH*CNT_W-1:0] r_snapDelay;
    logic [N_CH*CNT_W-1:0] r_snapDur;
    logic                  r_snapChain;
    logic                  r_active;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_busy;
    logic                  w_allDone;
    logic                  w_finish;
    logic                  w_chain;
    logic [N_CH-1:0]       w_en;
    logic [N_CH-1:0]       w_launch;
    logic [N_CH*CNT_W-1:0] w_delay;
    logic [N_CH*CNT_W-1:0] w_dur;
    chState_t              w_state [N_CH];
    logic [CNT_W-1:0]      w_cnt   [N_CH];

    always_comb begin
        w_busy    = 1'b0;
        w_allDone = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if ((w_state[i] == DELAY) || (w_state[i] == ASSERT)) begin
                w_busy = 1'b1;
            end
            if (r_snapEn[i] && (w_state[i] != DONE)) begin
                w_allDone = 1'b0;
            end
        end
    end

    // On the accepting edge the live inputs are used directly, since the snapshot only lands on that edge.
    assign w_accept = start & ~w_busy;
    assign w_finish = r_active & w_allDone;
    assign w_en     = w_accept ? ch_en      : r_snapEn;
    assign w_delay  = w_accept ? ch_delay   : r_snapDelay;
    assign w_dur    = w_accept ? ch_dur     : r_snapDur;
    assign w_chain  = w_accept ? chain_mode : r_snapChain;

    // The chain token ripples past disabled and zero-length channels within one cycle.
    always_comb begin
        logic tok;
        w_launch = '0;
        tok      = w_accept;
        for (int i = 0; i < N_CH; i++) begin
            if (w_chain) begin
                if (w_en[i]) begin
                    w_launch[i] = tok;
                    tok = entersDone(w_state[i], tok,
                                     w_cnt[i] == CNT_W'(1),
                                     w_delay[i*CNT_W +: CNT_W] == '0,
                                     w_dur[i*CNT_W +: CNT_W] == '0);
                end
            end else begin
                w_launch[i] = w_accept & w_en[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snapEn    <= '0;
            r_snapDelay <= '0;
            r_snapDur   <= '0;
            r_snapChain <= 1'b0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_snapEn    <= ch_en;
                r_snapDelay <= ch_delay;
                r_snapDur   <= ch_dur;
                r_snapChain <= chain_mode;
                r_active    <= 1'b1;
            end else if (w_finish) begin
                r_active <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : gCh
        rst_pulse_ch #(
            .CNT_W(CNT_W)
        ) uCh (
            .clk       (clk),
            .rst       (rst),
            .i_launch  (w_launch[g]),
            .i_clear   (w_finish),
            .i_pol     (ch_pol[g]),
            .i_delay   (w_delay[g*CNT_W +: CNT_W]),
            .i_dur     (w_dur[g*CNT_W +: CNT_W]),
            .o_state   (w_state[g]),
            .o_cnt     (w_cnt[g]),
            .o_rstOut  (rst_out[g])
`ifdef RST_PULSE_SEQ_CNT_EN
            ,
            .o_pulseCnt(pulse_cnt[g*PULSE_CNT_W +: PULSE_CNT_W])
`endif
        );
    end

    assign busy = w_busy;
    assign done = r_done;

endmodule

// File: tb/tb_rst_pulse_seq.sv
// Directed self-checking bench for rst_pulse_seq with hand-computed per-edge tables.
// Covers the pulse_cnt output as well when RST_PULSE_SEQ_CNT_EN is defined.
module tb_rst_pulse_seq;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  chain_mode;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH-1:0]       ch_pol;
    logic [N_CH*CNT_W-1:0] ch_delay;
    logic [N_CH*CNT_W-1:0] ch_dur;
    logic [N_CH-1:0]       rst_out;
    logic                  busy;
    logic                  done;
`ifdef RST_PULSE_SEQ_CNT_EN
    logic [N_CH*8-1:0]     pulse_cnt;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    rst_pulse_seq #(
        .N_CH (N_CH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chain_mode(chain_mode),
        .ch_en     (ch_en),
        .ch_pol    (ch_pol),
        .ch_delay  (ch_delay),
        .ch_dur    (ch_dur),
        .rst_out   (rst_out),
        .busy      (busy),
        .done      (done)
`ifdef RST_PULSE_SEQ_CNT_EN
        ,
        .pulse_cnt (pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Loads a configuration at the falling edge and raises start; the next rising edge is edge 0.
    task automatic applyStimulus(input logic chain, input logic [3:0] en, input logic [3:0] pol,
                                 input logic [63:0] dly, input logic [63:0] dur);
        @(negedge clk);
        chain_mode = chain;
        ch_en      = en;
        ch_pol     = pol;
        ch_delay   = dly;
        ch_dur     = dur;
        start      = 1'b1;
    endtask

    // Tables hold one entry per edge, edge 0 in the least significant position.
    task automatic checkRun(input string tag, input int n, input logic [127:0] rstTab,
                            input logic [31:0] doneTab, input logic [31:0] busyTab);
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            checkOutput($sformatf("%s rst_out e%0d", tag, e), {28'd0, rst_out}, {28'd0, rstTab[e*4 +: 4]});
            checkOutput($sformatf("%s done e%0d", tag, e), {31'd0, done}, {31'd0, doneTab[e]});
            checkOutput($sformatf("%s busy e%0d", tag, e), {31'd0, busy}, {31'd0, busyTab[e]});
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        chain_mode = 1'b0;
        ch_en      = '0;
        ch_pol     = 4'b1010;
        ch_delay   = '0;
        ch_dur     = '0;

        #3;
        checkOutput("reset rst_out", {28'd0, rst_out}, 32'h5);
        checkOutput("reset busy", {31'd0, busy}, 32'h0);
        checkOutput("reset done", {31'd0, done}, 32'h0);
        ch_pol = 4'b0011;
        #1;
        checkOutput("reset live pol", {28'd0, rst_out}, 32'hC);
        @(negedge clk);
        rst = 1'b0;

        // Parallel: delays 0/1/2/3, duration 2 each.
        applyStimulus(1'b0, 4'b1111, 4'b1111, {16'd3, 16'd2, 16'd1, 16'd0}, {4{16'd2}});
        checkRun("par", 8, 128'h008C6310, 32'h40, 32'h1F);

        // Chain over channels 0,1,3 with delay 1 and duration 3.
        applyStimulus(1'b1, 4'b1011, 4'b1111, {4{16'd1}}, {4{16'd3}});
        checkRun("chain", 16, 128'h0008880222011100, 32'h2000, 32'h0FFF);

        // Restart attempt and config changes while busy must not disturb the run.
        applyStimulus(1'b0, 4'b0011, 4'b1111, {16'd0, 16'd0, 16'd0, 16'd2}, {16'd0, 16'd0, 16'd3, 16'd1});
        fork
            begin
                repeat (2) @(negedge clk);
                start      = 1'b1;
                ch_delay   = {4{16'd5}};
                ch_dur     = {4{16'd7}};
                ch_en      = 4'b1111;
                chain_mode = 1'b1;
            end
        join_none
        checkRun("snap", 7, 128'h0003220, 32'h10, 32'h7);

        // Zero duration on an active-low channel: never asserted, done still produced.
        applyStimulus(1'b0, 4'b0011, 4'b1101, {16'd0, 16'd0, 16'd2, 16'd0}, {16'd0, 16'd0, 16'd0, 16'd1});
        checkRun("dur0", 5, 128'h22232, 32'h8, 32'h3);

        // Reset in the middle of ASSERT, then a full restart.
        applyStimulus(1'b0, 4'b1111, 4'b1111, 64'd0, {4{16'd5}});
        checkRun("prerst", 3, 128'hFF0, 32'h0, 32'h7);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst rst_out", {28'd0, rst_out}, 32'h0);
        checkOutput("midrst busy", {31'd0, busy}, 32'h0);
        checkOutput("midrst done", {31'd0, done}, 32'h0);
        ch_pol = 4'b0110;
        #1;
        checkOutput("midrst live pol", {28'd0, rst_out}, 32'h9);
        @(posedge clk);
        #1;
        checkOutput("inrst done", {31'd0, done}, 32'h0);
        checkOutput("inrst rst_out", {28'd0, rst_out}, 32'h9);
        ch_pol = 4'b1111;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        checkRun("restart", 8, 128'h00FFFFF0, 32'h40, 32'h1F);

        // No enabled channel: done one edge after start, busy never rises.
        applyStimulus(1'b0, 4'b0000, 4'b1111, 64'd0, 64'd0);
        checkRun("empty", 3, 128'h0, 32'h2, 32'h0);

`ifdef RST_PULSE_SEQ_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("cnt cleared", pulse_cnt, 32'h0);
        for (int r = 0; r < 300; r++) begin
            logic gotDone;
            applyStimulus(1'b0, 4'b0101, 4'b1111, 64'd0, {4{16'd1}});
            gotDone = 1'b0;
            for (int c = 0; c < 8 && !gotDone; c++) begin
                @(posedge clk);
                #1;
                start   = 1'b0;
                gotDone = done;
            end
            if (!gotDone) begin
                checkOutput($sformatf("cnt run %0d done timeout", r), 32'h0, 32'h1);
            end
            if (r == 99) begin
                checkOutput("cnt after 100", pulse_cnt, 32'h00640064);
            end
        end
        checkOutput("cnt saturated", pulse_cnt, 32'h00FF00FF);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
